// File: rtl/bus_master_dma.sv
// Single-channel bus-master copy engine: requests the shared bus, then copies
// `length` words from src to dst as read/write pairs, retrying a word on grant loss.
module bus_master_dma #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic              grant,
    output logic              req,
    output logic              wr,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] dout,
    input  logic [DATA_W-1:0] din,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {IDLE, REQ, RD, RD_WAIT, WR, DONE} state_t;

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] src_reg, src_next;
    logic [ADDR_W-1:0] dst_reg, dst_next;
    logic [LEN_W-1:0]  len_reg, len_next;
    logic [LEN_W-1:0]  idx_reg, idx_next;
    logic [DATA_W-1:0] buf_reg, buf_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] dout_reg, dout_next;
    logic              req_reg, busy_reg, done_reg, wr_state_reg;

    always_comb begin
        state_next = state_reg;
        src_next   = src_reg;
        dst_next   = dst_reg;
        len_next   = len_reg;
        idx_next   = idx_reg;
        buf_next   = buf_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        src_next   = src_addr;
                        dst_next   = dst_addr;
                        len_next   = length;
                        idx_next   = '0;
                        state_next = REQ;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            REQ: begin
                if (grant) state_next = RD;
            end
            RD: begin
                state_next = grant ? RD_WAIT : REQ;
            end
            RD_WAIT: begin
                if (grant) begin
                    buf_next   = din;
                    state_next = WR;
                end else begin
                    state_next = REQ;
                end
            end
            WR: begin
                // Losing grant here leaves idx alone so the word is redone from its read
                if (!grant) begin
                    state_next = REQ;
                end else if (idx_reg == len_reg - LEN_ONE) begin
                    state_next = DONE;
                end else begin
                    idx_next   = idx_reg + LEN_ONE;
                    state_next = RD;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus address/data are precomputed from the next state so they leave a register
    always_comb begin
        addr_next = '0;
        dout_next = '0;
        case (state_next)
            RD: addr_next = src_next + ADDR_W'(idx_next);
            WR: begin
                addr_next = dst_next + ADDR_W'(idx_next);
                dout_next = buf_next;
            end
            default: begin
                addr_next = '0;
                dout_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            src_reg      <= '0;
            dst_reg      <= '0;
            len_reg      <= '0;
            idx_reg      <= '0;
            buf_reg      <= '0;
            addr_reg     <= '0;
            dout_reg     <= '0;
            req_reg      <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            wr_state_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            src_reg      <= src_next;
            dst_reg      <= dst_next;
            len_reg      <= len_next;
            idx_reg      <= idx_next;
            buf_reg      <= buf_next;
            addr_reg     <= addr_next;
            dout_reg     <= dout_next;
            req_reg      <= (state_next == REQ) || (state_next == RD) ||
                            (state_next == RD_WAIT) || (state_next == WR);
            busy_reg     <= (state_next != IDLE);
            done_reg     <= (state_next == DONE);
            wr_state_reg <= (state_next == WR);
        end
    end

    // Write strobe is gated by the live grant so nothing is written after losing the bus
    assign wr   = wr_state_reg & grant;
    assign req  = req_reg;
    assign addr = addr_reg;
    assign dout = dout_reg;
    assign busy = busy_reg;
    assign done = done_reg;

endmodule

// File: doc/bus_master_dma.md
# bus_master_dma

Single-channel copy engine acting as one bus master on the shared two-master bus. It raises a request toward the bus arbiter, waits for its grant bit, then moves `length` words from a source region to a destination region, one read plus one write per word, and releases the bus when done. It sits directly upstream of the arbiter, as the M0 or M1 requester, and drives the master-side address/data/write lines into the bus multiplexer.

## Interface
- `ADDR_W`, 8: bus address width.
- `DATA_W`, 32: bus data width.
- `LEN_W`, 8: transfer-length width.

- `clk`  input  1  single system clock, all state on rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `start`  input  1  one-cycle command strobe. Sampled only in IDLE.
- `src_addr`  input  ADDR_W  first source word address. Latched on accepted `start`.
- `dst_addr`  input  ADDR_W  first destination word address. Latched on accepted `start`.
- `length`  input  LEN_W  number of words to copy. Latched on accepted `start`.
- `grant`  input  1  this master's grant bit from the arbiter.
- `req`  output  1  bus request to the arbiter.
- `wr`  output  1  bus write enable. 0 means read.
- `addr`  output  ADDR_W  bus address.
- `dout`  output  DATA_W  bus write data.
- `din`  input  DATA_W  bus read data, valid one cycle after the read address.
- `busy`  output  1  command in progress.
- `done`  output  1  one-cycle completion pulse.

## Operation
- Registers: state, `src`, `dst`, `len`, word index `idx` (LEN_W), data buffer `buf` (DATA_W).
- FSM states: IDLE, REQ, RD, RD_WAIT, WR, DONE.
- IDLE:
  - On `start`=1 with `length`≠0: latch operands, `idx`←0, go to REQ.
  - On `start`=1 with `length`=0: go to DONE without ever asserting `req`.
- REQ: `req`=1. If `grant`=1, go to RD.
- RD: `addr`=`src`+`idx`, `wr`=0. Go to RD_WAIT.
- RD_WAIT: `buf`←`din`. Go to WR.
- WR:
  - Outputs: `addr`=`dst`+`idx`, `dout`=`buf`, `wr`=1.
  - If `idx`=`len`−1, go to DONE.
  - Otherwise `idx`←`idx`+1 and go to RD.
- DONE: `done`=1 for one cycle, `req`=0, go to IDLE.
- `req`=1 in REQ, RD, RD_WAIT and WR, so the grant is held for the whole burst.
- Grant loss: if `grant`=0 while in RD, RD_WAIT or WR:
  - Go to REQ; `idx` is unchanged.
  - The current word is redone from its read.
  - Words already written are not repeated.
- `wr` = (state==WR) & `grant`, so no write is issued without grant.
- `addr` and `dout` are decoded from state registers. They are 0 in IDLE, REQ and DONE.
- Address arithmetic is modulo 2^ADDR_W: `src`+`idx` and `dst`+`idx` wrap silently.
- `start` while `busy`=1 is ignored; latched operands are not disturbed.
- `busy`=1 in every state except IDLE.

## Timing
- Reset (asynchronous, any state): state=IDLE, `req`=0, `wr`=0, `addr`=0, `dout`=0, `busy`=0, `done`=0, `idx`=0, `buf`=0.
- Reset mid-burst: the transfer is abandoned. No partial-completion `done`.
- `start` accepted at edge N: `busy`=1 and `req`=1 from cycle N+1.
- With `grant` already high at the first REQ edge, RD begins one cycle after REQ entry.
- Each word costs 3 cycles (RD, RD_WAIT, WR) while grant is held.
- Total latency, `start` accepted to `done` pulse, with grant available immediately: 1 (REQ) + 3·`length` + 1 (DONE) cycles.
- `length`=0: `done` in cycle N+1, `req` never asserted.
- `req` drops in the DONE cycle, letting the arbiter hand the bus to the other master on the following edge.
- Maximum `length` = 2^LEN_W−1. The `idx`=`len`−1 compare uses the full LEN_W width.

## Test plan
- Single word: `src`=0x10, `dst`=0x20, `length`=1, `grant` tied 1, memory[0x10]=0xDEADBEEF.
  - Response: one read at 0x10, then a write of 0xDEADBEEF at 0x20.
  - `done` exactly 5 cycles after `start`.
- Burst of 4: `src`=0x00, `dst`=0x80, `grant` high.
  - Response: writes at 0x80–0x83 carry memory[0x00–0x03] in order.
  - `busy` is high for 14 cycles; `req` falls in the `done` cycle.
- Delayed grant: `grant` held 0 for 6 cycles after `start`.
  - Response: `req`=1 throughout, no bus activity, `wr` stays 0.
  - The copy proceeds normally once `grant`=1.
- Grant loss in WR of word 2 of 4:
  - Response: no write while `grant`=0; FSM returns to REQ.
  - Word 2 is re-read and written after re-grant; words 0–1 are not rewritten.
  - The final destination contents are correct.
- Wrap and zero length:
  - `src`=0xFE, `length`=3 reads 0xFE, 0xFF, 0x00.
  - `length`=0 gives `done` one cycle after `start` with `req` never high.
- Reset mid-burst: assert `reset` during RD_WAIT of word 1.
  - Response: all outputs read 0 immediately, without waiting for a clock edge.
  - After release, a new `start` executes cleanly.
